// File: rtl/alu_dispatch_if.sv
// Command, ALU and response signal bundle for alu_dispatch.
// The slave modport is the dispatcher's view; the master modport is its environment's view.
interface alu_dispatch_if;
    localparam int unsigned OPR_W  = 5;
    localparam int unsigned DATA_W = 64;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OPR_W-1:0]  cmd_opr;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;

    logic              alu_start;
    logic [OPR_W-1:0]  alu_opr;
    logic [DATA_W-1:0] alu_inA;
    logic [DATA_W-1:0] alu_inB;
    logic              alu_done;
    logic [DATA_W-1:0] alu_outAB;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport slave (
        input  cmd_valid, cmd_opr, cmd_a, cmd_b, alu_done, alu_outAB, rsp_ready,
        output cmd_ready, alu_start, alu_opr, alu_inA, alu_inB, rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output cmd_valid, cmd_opr, cmd_a, cmd_b, alu_done, alu_outAB, rsp_ready,
        input  cmd_ready, alu_start, alu_opr, alu_inA, alu_inB, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_dispatch.sv
// Queues ALU commands in a small FIFO and runs them one at a time through an external ALU,
// returning the result (or an error on illegal opcode / ALU timeout) over a valid/ready response port.
module alu_dispatch #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_dispatch_if.slave          dp_if,
    output logic [$clog2(DEPTH):0] fifo_level_o,
    output logic                   busy_o
);
    localparam int unsigned OPR_W   = 5;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned ENTRY_W = OPR_W + 2 * DATA_W;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned MAX_OPR = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPT,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [ENTRY_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]    level_q;
    logic [OPR_W-1:0]    opr_q, opr_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;

    logic                push, pop;
    logic [OPR_W-1:0]    head_opr;
    logic [DATA_W-1:0]   head_a, head_b;

    // Ready depends only on registered occupancy, so a same-cycle pop never frees a full FIFO.
    assign dp_if.cmd_ready = (level_q < LVL_W'(DEPTH));
    assign push = dp_if.cmd_valid && dp_if.cmd_ready;
    assign pop  = (state_q == S_IDLE) && (level_q != '0);
    assign {head_opr, head_a, head_b} = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {dp_if.cmd_opr, dp_if.cmd_a, dp_if.cmd_b};
        end
    end

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            opr_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            opr_q      <= opr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        opr_d      = opr_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    opr_d   = head_opr;
                    a_d     = head_a;
                    b_d     = head_b;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (opr_q > OPR_W'(MAX_OPR)) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                    state_d    = S_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dp_if.alu_done) begin
                    state_d = S_CAPT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // The TIMEOUT-th cycle without done aborts the command.
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = S_RESP;
                    end
                end
            end
            S_CAPT: begin
                rsp_data_d = dp_if.alu_outAB;
                rsp_err_d  = 1'b0;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (dp_if.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dp_if.alu_start = (state_q == S_WAIT) || (state_q == S_CAPT);
    assign dp_if.alu_opr   = opr_q;
    assign dp_if.alu_inA   = a_q;
    assign dp_if.alu_inB   = b_q;
    assign dp_if.rsp_valid = (state_q == S_RESP);
    assign dp_if.rsp_data  = rsp_data_q;
    assign dp_if.rsp_err   = rsp_err_q;

    assign fifo_level_o = level_q;
    assign busy_o       = (state_q != S_IDLE) || (level_q != '0);
endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch: a driver queues expected responses, a negedge monitor scores them.
module tb_alu_dispatch;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 63;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] fifo_level;
    logic       busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    int alu_cyc      = 0;
    int done_delay   = 1000;
    int start_cycles = 0;
    int rsp_seen     = 0;

    alu_dispatch_if ifc ();

    alu_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .dp_if        (ifc),
        .fifo_level_o (fifo_level),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // ALU model: done after done_delay full cycles of alu_start; opcode 2 adds, others xor.
    always @(negedge clk) begin
        if (!ifc.alu_start) alu_cyc = 0;
        else                alu_cyc = alu_cyc + 1;
        if (ifc.alu_start) start_cycles = start_cycles + 1;
        if (ifc.rsp_valid) rsp_seen = rsp_seen + 1;
    end
    assign ifc.alu_done  = ifc.alu_start && (alu_cyc >= done_delay);
    assign ifc.alu_outAB = (ifc.alu_opr == 5'd2) ? (ifc.alu_inA + ifc.alu_inB)
                                                 : (ifc.alu_inA ^ ifc.alu_inB);

    // Scoreboard monitor: every response handshake is checked against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ifc.rsp_valid && ifc.rsp_ready) begin
            n_tests = n_tests + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL rsp_unexpected: got data=%0h err=%0b, required no response",
                         ifc.rsp_data, ifc.rsp_err);
            end else begin
                e = exp_q.pop_front();
                if (ifc.rsp_data !== e.data || ifc.rsp_err !== e.err) begin
                    n_fail = n_fail + 1;
                    $display("FAIL rsp_payload: got data=%0h err=%0b, required data=%0h err=%0b",
                             ifc.rsp_data, ifc.rsp_err, e.data, e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests = n_tests + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] opr, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] ed, input logic ee);
        int   n;
        exp_t e;
        ifc.cmd_opr   = opr;
        ifc.cmd_a     = a;
        ifc.cmd_b     = b;
        ifc.cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ifc.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.cmd_ready) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL send_timeout: cmd_ready=0 after %0d cycles, required 1", n);
        end else begin
            e.data = ed;
            e.err  = ee;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, 64'(ifc.cmd_ready), 64'd1);
        check({tag, "_alu_start"}, 64'(ifc.alu_start), 64'd0);
        check({tag, "_alu_opr"},   64'(ifc.alu_opr),   64'd0);
        check({tag, "_alu_inA"},   ifc.alu_inA,        64'd0);
        check({tag, "_alu_inB"},   ifc.alu_inB,        64'd0);
        check({tag, "_rsp_valid"}, 64'(ifc.rsp_valid), 64'd0);
        check({tag, "_rsp_data"},  ifc.rsp_data,       64'd0);
        check({tag, "_rsp_err"},   64'(ifc.rsp_err),   64'd0);
        check({tag, "_level"},     64'(fifo_level),    64'd0);
        check({tag, "_busy"},      64'(busy),          64'd0);
    endtask

    initial begin
        int n;
        int s0;
        int r0;
        exp_t e;

        rst           = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_opr   = '0;
        ifc.cmd_a     = '0;
        ifc.cmd_b     = '0;
        ifc.rsp_ready = 1'b1;

        // Reset takes effect before any clock edge.
        #2 rst = 1'b1;
        #1 check_reset_vals("por");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tick();

        // Legal op, done in first WAIT cycle: response 4 cycles after push.
        done_delay = 1;
        s0 = start_cycles;
        send(5'd2, 64'd5, 64'd7, 64'd12, 1'b0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ifc.rsp_valid && n < 20);
        check("latency_legal", 64'(n), 64'd4);
        check("rsp_data_legal", ifc.rsp_data, 64'd12);
        wait_drain("drain_legal");
        check("start_cycles_legal", 64'(start_cycles - s0), 64'd2);

        // Illegal opcode: error response, ALU never started.
        s0 = start_cycles;
        send(5'd15, 64'd1, 64'd2, 64'd0, 1'b1);
        wait_drain("drain_illegal");
        check("start_cycles_illegal", 64'(start_cycles - s0), 64'd0);

        // ALU never completes: aborted after TIMEOUT WAIT cycles.
        done_delay = 1000;
        s0 = start_cycles;
        send(5'd5, 64'd3, 64'd4, 64'd0, 1'b1);
        wait_drain("drain_timeout");
        check("start_cycles_timeout", 64'(start_cycles - s0), 64'd63);
        check("alu_start_after_timeout", 64'(ifc.alu_start), 64'd0);

        // Stalled response: five commands fill RESP plus a full FIFO.
        done_delay    = 2;
        ifc.rsp_ready = 1'b0;
        send(5'd2, 64'd1, 64'd10, 64'd11, 1'b0);
        send(5'd3, 64'd6, 64'd3, 64'd5, 1'b0);
        send(5'd2, 64'd100, 64'd28, 64'd128, 1'b0);
        send(5'd3, 64'd15, 64'd15, 64'd0, 1'b0);
        send(5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0);
        repeat (4) tick();
        check("full_level", 64'(fifo_level), 64'd4);
        check("full_cmd_ready", 64'(ifc.cmd_ready), 64'd0);
        check("stall_rsp_valid", 64'(ifc.rsp_valid), 64'd1);
        check("stall_rsp_data", ifc.rsp_data, 64'd11);
        check("stall_busy", 64'(busy), 64'd1);
        ifc.rsp_ready = 1'b1;
        wait_drain("drain_full");

        // Simultaneous push and pop at level 2, across the pointer wrap.
        done_delay    = 1;
        ifc.rsp_ready = 1'b0;
        send(5'd2, 64'd3, 64'd4, 64'd7, 1'b0);
        send(5'd3, 64'd5, 64'd1, 64'd4, 1'b0);
        send(5'd2, 64'd20, 64'd22, 64'd42, 1'b0);
        n = 0;
        while (!ifc.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check("pp_pre_level", 64'(fifo_level), 64'd2);
        ifc.rsp_ready = 1'b1;
        tick();
        check("pp_cmd_ready", 64'(ifc.cmd_ready), 64'd1);
        ifc.cmd_opr   = 5'd3;
        ifc.cmd_a     = 64'd255;
        ifc.cmd_b     = 64'd15;
        ifc.cmd_valid = 1'b1;
        e.data = 64'd240;
        e.err  = 1'b0;
        exp_q.push_back(e);
        tick();
        ifc.cmd_valid = 1'b0;
        check("pp_level", 64'(fifo_level), 64'd2);
        wait_drain("drain_pp");

        // Reset while WAITing with two queued: everything discarded.
        done_delay = 1000;
        send(5'd1, 64'd9, 64'd6, 64'd15, 1'b0);
        send(5'd2, 64'd1, 64'd1, 64'd2, 1'b0);
        send(5'd3, 64'd2, 64'd2, 64'd0, 1'b0);
        check("pre_rst_alu_start", 64'(ifc.alu_start), 64'd1);
        check("pre_rst_level", 64'(fifo_level), 64'd2);
        #2 rst = 1'b1;
        #1 check_reset_vals("midrst");
        exp_q.delete();
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        r0 = rsp_seen;
        repeat (20) tick();
        check("post_rst_no_rsp", 64'(rsp_seen - r0), 64'd0);
        check("post_rst_level", 64'(fifo_level), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);

        // Normal operation resumes after reset.
        done_delay = 1;
        send(5'd2, 64'd100, 64'd200, 64'd300, 1'b0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ifc.rsp_valid && n < 20);
        check("latency_after_rst", 64'(n), 64'd4);
        wait_drain("drain_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
